mrr_decoded_merge: RTL and testbench

MRR_DECODED_MERGE -- requirements
Module: mrr_decoded_merge

---
 rtl/mrr_decoded_merge.sv | 175 +++++++++++++++++
 tb/tb_mrr_decoded_merge.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrr_decoded_merge.sv
// mrr_decoded_merge: round-robin, packet-atomic merge of NUM_PATHWAYS
// decoded word streams onto one stream, each packet preceded by a header.
// Ports: clk, rst (async active-low); i_tdata/i_tvalid/i_tlast/i_tready
// per pathway; o_tdata/o_tvalid/o_tlast/o_tready merged; pkt_count and
// drop_count statistics. Optional macro MRR_MERGE_TIMEOUT_EN adds the
// mid-packet stall timeout and the ABORT state.
module mrr_decoded_merge #(
  parameter int NUM_PATHWAYS   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [32*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]   i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]   i_tlast,
  output logic [NUM_PATHWAYS-1:0]   i_tready,
  output logic [31:0]               o_tdata,
  output logic                      o_tvalid,
  output logic                      o_tlast,
  input  logic                      o_tready,
  output logic [15:0]               pkt_count,
  output logic [15:0]               drop_count
);

  localparam int SW = (NUM_PATHWAYS > 1) ?
                      $clog2(NUM_PATHWAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_ABORT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_last;
  logic [7:0]    r_seq [NUM_PATHWAYS];
  logic [15:0]   r_pkt;

  logic          w_found;
  logic [SW-1:0] w_gnt;
  int            w_k;
  logic [31:0]   w_sd;
  logic          w_sv;
  logic          w_sl;
  logic          w_end;

`ifdef MRR_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  logic [15:0]   r_drop;
  logic          w_expire;
`endif

  // Round-robin search starting just above the last granted pathway.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_k     = 0;
    for (int i = 1; i <= NUM_PATHWAYS; i++) begin
      w_k = (int'(r_last) + i) % NUM_PATHWAYS;
      if (!w_found && i_tvalid[w_k]) begin
        w_found = 1'b1;
        w_gnt   = SW'(w_k);
      end
    end
  end

  assign w_sd  = i_tdata[32*int'(r_sel) +: 32];
  assign w_sv  = i_tvalid[r_sel];
  assign w_sl  = i_tlast[r_sel];
  assign w_end = w_sv & w_sl & o_tready;

`ifdef MRR_MERGE_TIMEOUT_EN
  assign w_expire = !w_sv &&
                    (r_to == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_found) w_next = S_HDR;
      S_HDR:  if (o_tready) w_next = S_DATA;
      S_DATA: begin
        if (w_end) w_next = S_IDLE;
`ifdef MRR_MERGE_TIMEOUT_EN
        else if (w_expire) w_next = S_ABORT;
`endif
      end
`ifdef MRR_MERGE_TIMEOUT_EN
      S_ABORT: if (o_tready) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = 32'h0;
    i_tready = '0;
    unique case (r_state)
      S_HDR: begin
        o_tvalid = 1'b1;
        o_tdata  = {8'hC5, 8'(r_sel),
                    r_seq[r_sel], 8'h00};
      end
      S_DATA: begin
        o_tvalid        = w_sv;
        o_tlast         = w_sl;
        o_tdata         = w_sd;
        i_tready[r_sel] = o_tready;
      end
`ifdef MRR_MERGE_TIMEOUT_EN
      S_ABORT: begin
        o_tvalid = 1'b1;
        o_tlast  = 1'b1;
        o_tdata  = 32'hDEAD0000;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel  <= '0;
      r_last <= SW'(NUM_PATHWAYS - 1);
      r_pkt  <= '0;
      for (int i = 0; i < NUM_PATHWAYS; i++)
        r_seq[i] <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_sel  <= w_gnt;
        r_last <= w_gnt;
      end
      if (r_state == S_HDR && o_tready)
        r_seq[r_sel] <= r_seq[r_sel] + 8'd1;
      if (r_state == S_DATA && w_end)
        r_pkt <= r_pkt + 16'd1;
    end
  end

  assign pkt_count = r_pkt;

`ifdef MRR_MERGE_TIMEOUT_EN
  // Counts consecutive starved cycles of the granted pathway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to   <= '0;
      r_drop <= '0;
    end else begin
      if (r_state == S_DATA && !w_sv &&
          w_next == S_DATA)
        r_to <= r_to + 1'b1;
      else
        r_to <= '0;
      if (r_state == S_ABORT && o_tready)
        r_drop <= r_drop + 16'd1;
    end
  end

  assign drop_count = r_drop;
`else
  assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_mrr_decoded_merge.sv
// tb_mrr_decoded_merge: vector table, hand sequences and a randomized
// run against a transaction-level round-robin packet model.
module tb_mrr_decoded_merge;

  localparam int NP = 4;
`ifdef MRR_MERGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [32*NP-1:0] i_tdata;
  logic [NP-1:0]    i_tvalid;
  logic [NP-1:0]    i_tlast;
  logic [NP-1:0]    i_tready;
  logic [31:0]      o_tdata;
  logic             o_tvalid;
  logic             o_tlast;
  logic             o_tready;
  logic [15:0]      pkt_count;
  logic [15:0]      drop_count;

  mrr_decoded_merge #(
    .NUM_PATHWAYS  (NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_tdata   (i_tdata),
    .i_tvalid  (i_tvalid),
    .i_tlast   (i_tlast),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tvalid  (o_tvalid),
    .o_tlast   (o_tlast),
    .o_tready  (o_tready),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wrd(input int k,
                                      input logic [7:0] tag);
    return 32'hD000_0000 | (32'(k) << 24) | 32'(tag);
  endfunction

  task automatic drv(input logic [NP-1:0] tv,
                     input logic [NP-1:0] tl,
                     input logic [7:0] tag);
    i_tvalid = tv;
    i_tlast  = tl;
    for (int k = 0; k < NP; k++)
      i_tdata[32*k +: 32] = wrd(k, tag);
  endtask

  // Model state: round-robin pointer, header sequence numbers, packets.
  int          m_last;
  logic [7:0]  m_seq [NP];
  logic [15:0] m_pkt;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          p;
    bit          hdr;
  } exp_t;

  logic [32:0] srcq [NP][$];
  exp_t        expq [$];
  bit          mid  [NP];
  bit          held [NP];
  int          bub  [NP];

  task automatic do_reset();
    @(negedge clk);
    drv('0, '0, 8'h00);
    o_tready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ovalid", 32'(o_tvalid), 0);
    chk("rst_olast", 32'(o_tlast), 0);
    chk("rst_odata", o_tdata, 0);
    chk("rst_itready", 32'(i_tready), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    @(negedge clk);
    rst = 1'b1;
    m_last = NP - 1;
    m_pkt  = '0;
    for (int k = 0; k < NP; k++) begin
      m_seq[k] = '0;
      mid[k] = 0;
      held[k] = 0;
      bub[k] = 0;
      srcq[k].delete();
    end
    expq.delete();
  endtask

  // Whole-packet round robin over the queued packets.
  task automatic build_exp();
    logic [32:0] cq [NP][$];
    bit any;
    for (int k = 0; k < NP; k++) cq[k] = srcq[k];
    any = 1;
    while (any) begin
      any = 0;
      for (int i = 1; i <= NP && !any; i++) begin
        int k;
        k = (m_last + i) % NP;
        if (cq[k].size() > 0) begin
          logic [32:0] w;
          any = 1;
          expq.push_back('{{8'hC5, 8'(k), m_seq[k], 8'h00},
                           1'b0, k, 1'b1});
          do begin
            w = cq[k].pop_front();
            expq.push_back('{w[31:0], w[32], k, 1'b0});
          end while (!w[32]);
          m_seq[k]++;
          m_pkt++;
          m_last = k;
        end
      end
    end
  endtask

  task automatic run(input int budget, input int mode);
    int cyc = 0;
    bit pst = 0;
    logic [31:0] pd = '0;
    logic pl = 0;
    logic [NP-1:0] er;
    exp_t e;
    while (expq.size() > 0 && cyc < budget) begin
      @(negedge clk);
      for (int k = 0; k < NP; k++) begin
        if (srcq[k].size() > 0) begin
          bit v;
          i_tdata[32*k +: 32] = srcq[k][0][31:0];
          i_tlast[k] = srcq[k][0][32];
          v = 1;
          if (mid[k] && !held[k] && bub[k] < 3 &&
              $urandom_range(0, 3) == 0)
            v = 0;
          i_tvalid[k] = v;
          bub[k] = v ? 0 : bub[k] + 1;
        end else begin
          i_tvalid[k] = 1'b0;
          i_tlast[k] = 1'b0;
        end
      end
      case (mode)
        0: o_tready = 1'b1;
        1: o_tready = (cyc % 2 == 0);
        default: o_tready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      er = '0;
      if (!expq[0].hdr && o_tready) er[expq[0].p] = 1'b1;
      chk("itready", 32'(i_tready), 32'(er));
      if (pst) begin
        chk("hold_valid", 32'(o_tvalid), 1);
        chk("hold_data", o_tdata, pd);
        chk("hold_last", 32'(o_tlast), 32'(pl));
      end
      if (o_tvalid && o_tready) begin
        e = expq.pop_front();
        chk("odata", o_tdata, e.d);
        chk("olast", 32'(o_tlast), 32'(e.l));
      end
      for (int k = 0; k < NP; k++)
        if (i_tvalid[k] && i_tready[k]) begin
          mid[k] = !srcq[k][0][32];
          void'(srcq[k].pop_front());
        end
      for (int k = 0; k < NP; k++)
        held[k] = i_tvalid[k] && !i_tready[k];
      pst = o_tvalid && !o_tready;
      pd = o_tdata;
      pl = o_tlast;
      cyc++;
    end
    if (expq.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL run_budget: %0d items left, required 0",
               expq.size());
      expq.delete();
      for (int k = 0; k < NP; k++) srcq[k].delete();
    end
    @(posedge clk);
    #1;
    i_tvalid = '0;
    chk("run_pkt", 32'(pkt_count), 32'(m_pkt));
  endtask

  typedef struct {
    bit          rb;
    logic [3:0]  tv;
    logic [3:0]  tl;
    logic [7:0]  tag;
    bit          rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  er;
    logic [15:0] ep;
  } vec_t;

  function automatic vec_t mk(bit rb, logic [3:0] tv,
                              logic [3:0] tl, logic [7:0] tag,
                              bit rdy, logic ev,
                              logic [31:0] ed, logic el,
                              logic [3:0] er, logic [15:0] ep);
    return '{rb, tv, tl, tag, rdy, ev, ed, el, er, ep};
  endfunction

  vec_t tbl [21];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drv('0, '0, 8'h00);
    o_tready = 1'b0;

    // Single 3-word packet on pathway 2.
    tbl[0] = mk(1, 4'b0100, 4'h0, 8'h01, 1, 0, 32'h0, 0, 4'h0, 0);
    tbl[1] = mk(0, 4'b0100, 4'h0, 8'h01, 1, 1,
                32'hC5020000, 0, 4'h0, 0);
    tbl[2] = mk(0, 4'b0100, 4'h0, 8'h01, 1, 1,
                32'hD2000001, 0, 4'b0100, 0);
    tbl[3] = mk(0, 4'b0100, 4'h0, 8'h02, 1, 1,
                32'hD2000002, 0, 4'b0100, 0);
    tbl[4] = mk(0, 4'b0100, 4'b0100, 8'h03, 1, 1,
                32'hD2000003, 1, 4'b0100, 0);
    tbl[5] = mk(0, 4'h0, 4'h0, 8'h00, 1, 0, 32'h0, 0, 4'h0, 1);
    // All pathways valid, 1-word packets: order 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      int p;
      int b;
      p = j % 4;
      b = 6 + 3 * j;
      tbl[b] = mk(j == 0, 4'hF, 4'hF, 8'h05, 1, 0,
                  32'h0, 0, 4'h0, 16'(j));
      tbl[b+1] = mk(0, 4'hF, 4'hF, 8'h05, 1, 1,
                    {8'hC5, 8'(p), 8'(j / 4), 8'h00},
                    0, 4'h0, 16'(j));
      tbl[b+2] = mk(0, 4'hF, 4'hF, 8'h05, 1, 1,
                    wrd(p, 8'h05), 1, 4'(1 << p), 16'(j));
    end

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rb) do_reset();
      @(negedge clk);
      drv(tbl[i].tv, tbl[i].tl, tbl[i].tag);
      o_tready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_ovalid", i), 32'(o_tvalid),
          32'(tbl[i].ev));
      chk($sformatf("v%0d_odata", i), o_tdata, tbl[i].ed);
      chk($sformatf("v%0d_olast", i), 32'(o_tlast),
          32'(tbl[i].el));
      chk($sformatf("v%0d_itready", i), 32'(i_tready),
          32'(tbl[i].er));
      chk($sformatf("v%0d_pkt", i), 32'(pkt_count),
          32'(tbl[i].ep));
    end

    // 4-word packet with o_tready toggling every cycle.
    do_reset();
    for (int w = 1; w <= 4; w++)
      srcq[0].push_back({w == 4, 32'hD00000A0 | 32'(w)});
    build_exp();
    run(60, 1);

    // Reset in the middle of a pathway 3 packet.
    do_reset();
    o_tready = 1'b1;
    @(negedge clk);
    drv(4'b1000, 4'h0, 8'h07);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_ovalid", 32'(o_tvalid), 1);
    chk("mid_odata", o_tdata, wrd(3, 8'h07));
    rst = 1'b0;
    #1;
    chk("arst_ovalid", 32'(o_tvalid), 0);
    chk("arst_odata", o_tdata, 0);
    chk("arst_olast", 32'(o_tlast), 0);
    chk("arst_itready", 32'(i_tready), 0);
    @(negedge clk);
    drv(4'b1010, 4'b1010, 8'h09);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ovalid", 32'(o_tvalid), 0);
    @(negedge clk);
    #1;
    chk("rel_hdr", o_tdata, 32'hC5010000);
    chk("rel_hlast", 32'(o_tlast), 0);
    @(negedge clk);
    #1;
    chk("rel_data", o_tdata, wrd(1, 8'h09));
    chk("rel_itready", 32'(i_tready), 32'b0010);

`ifdef MRR_MERGE_TIMEOUT_EN
    // Pathway 1 starves after one word and is aborted.
    do_reset();
    o_tready = 1'b1;
    @(negedge clk);
    drv(4'b0010, 4'h0, 8'h01);
    #1;
    chk("to_idle", 32'(o_tvalid), 0);
    @(negedge clk);
    #1;
    chk("to_hdr", o_tdata, 32'hC5010000);
    @(negedge clk);
    #1;
    chk("to_word", o_tdata, wrd(1, 8'h01));
    @(negedge clk);
    drv(4'b0001, 4'b0001, 8'h02);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("to_wait%0d", i), 32'(o_tvalid), 0);
    end
    @(negedge clk);
    #1;
    chk("abort_valid", 32'(o_tvalid), 1);
    chk("abort_data", o_tdata, 32'hDEAD0000);
    chk("abort_last", 32'(o_tlast), 1);
    @(negedge clk);
    #1;
    chk("abort_drop", 32'(drop_count), 1);
    chk("abort_pkt", 32'(pkt_count), 0);
    chk("abort_idle", 32'(o_tvalid), 0);
    @(negedge clk);
    #1;
    chk("abort_next_hdr", o_tdata, 32'hC5000000);
`endif

    // Randomized packets on all pathways against the model.
    do_reset();
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < NP; k++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int w = 0; w < len; w++)
            srcq[k].push_back({w == len - 1, 32'($urandom)});
        end
      end
      build_exp();
      run(600, 2);
    end

    // Enough packets on one pathway to wrap its 8-bit sequence.
    for (int p = 0; p < 260; p++)
      srcq[0].push_back({1'b1, 32'($urandom)});
    build_exp();
    run(2000, 0);
    chk("drop_final", 32'(drop_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
